uart_cmd_sender: RTL and testbench
==================================

// Module: uart_cmd_sender
// PURPOSE
//  Host-side command initiator for the UART command link. Serialises a multi-byte
//  command MSB-byte-first through a UART transmitter (trmt/tx_data/tx_done), then
//  waits for the single-byte response (rdy/rx_data/clr_rdy) from the remote
//  command receiver. Sits between test/host logic and a UART tx/rx pair.
// PARAMETERS
//  NUM_BYTES     3          command length in bytes (cmd width = 8*NUM_BYTES), >=1
//  RESP_TIMEOUT  1_000_000  clk cycles to wait for response (used only with RESP_TIMEOUT_EN)
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst_n      in   1              asynchronous active-low reset
//  snd_cmd    in   1              1-cycle pulse: start sending cmd
//  cmd        in   8*NUM_BYTES    command word, captured on accepted snd_cmd
//  trmt       out  1              1-cycle pulse to UART tx: load tx_data
//  tx_data    out  8              byte to UART tx
//  tx_done    in   1              UART tx byte-complete level (cleared by UART on trmt)
//  rdy        in   1              UART rx byte-available level (held until clr_rdy)
//  rx_data    in   8              UART rx received byte
//  clr_rdy    out  1              1-cycle pulse to UART rx: consume byte
//  busy       out  1              high from accepted snd_cmd until response/timeout
//  cmd_sent   out  1              1-cycle pulse after last byte's tx_done rises
//  resp_rdy   out  1              response valid; held until next accepted snd_cmd
//  resp       out  8              captured response byte
//  timeout    out  1              response timed out; held until next accepted snd_cmd
// BEHAVIOUR
//  Reset: state IDLE; trmt, clr_rdy, busy, cmd_sent, resp_rdy, timeout = 0; resp, tx_data = 0.
//  States: IDLE -> LOAD -> WAIT_TX -> (LOAD | WAIT_RESP) -> IDLE.
//  IDLE: snd_cmd=1 -> capture cmd to shift reg, byte_cnt=0, clear resp_rdy/timeout,
//   pulse clr_rdy (flush stale rx byte), busy=1, go LOAD.
//  LOAD: tx_data = shift_reg[MSB byte]; trmt=1 for exactly this cycle; go WAIT_TX.
//  WAIT_TX: wait for rising edge of tx_done (tx_done & ~tx_done_q; tx_done_q registered
//   every cycle). On edge: shift reg left 8, byte_cnt++; if byte_cnt was NUM_BYTES-1
//   -> pulse cmd_sent, go WAIT_RESP; else go LOAD. Min. 2 cycles per byte beyond UART time.
//  tx_data holds its value from LOAD through WAIT_TX (stable while UART shifts).
//  WAIT_RESP: rdy=1 -> resp<=rx_data, resp_rdy=1, pulse clr_rdy, busy=0, go IDLE.
//   A byte arriving during transmit stays pending (rdy level) and is taken on entry.
//  snd_cmd while busy: ignored, no effect on cmd capture or state.
//  snd_cmd same cycle as response capture: ignored (IDLE not yet reached).
//  tx_done already high at LOAD (previous byte): no false edge, edge detect requires low->high.
//  rst_n low mid-transfer: immediate return to reset values; trmt drops same instant.
//  byte_cnt width $clog2(NUM_BYTES+1); NUM_BYTES=1 sends one byte then WAIT_RESP.
// CONFIGURATION
//  RESP_TIMEOUT_EN defined: counter (width $clog2(RESP_TIMEOUT+1)) zeroed on entry to
//   WAIT_RESP, increments each cycle; reaching RESP_TIMEOUT-1 with rdy=0 -> timeout=1,
//   busy=0, go IDLE, resp unchanged. rdy on the terminal cycle wins over timeout.
//  RESP_TIMEOUT_EN undefined: no counter; WAIT_RESP waits indefinitely; timeout tied 0.
// TESTING
//  1 reset: rst_n=0 -> all outputs 0, state IDLE; release, no activity with snd_cmd=0.
//  2 cmd=24'hA5_3C_0F, snd_cmd -> trmt pulses with tx_data A5,3C,0F in order, one per
//    tx_done rise; cmd_sent pulse after 3rd; rx_data=8'hA5,rdy -> resp=A5, resp_rdy=1, clr_rdy pulse.
//  3 snd_cmd re-pulsed mid-transfer with cmd=24'hFFFFFF -> ignored; bytes still A5,3C,0F.
//  4 rdy held high (stale 8'h11) before snd_cmd -> clr_rdy flush on accept; later 8'h5A -> resp=5A.
//  5 RESP_TIMEOUT_EN, RESP_TIMEOUT=50, no rdy -> timeout=1 exactly 50 cycles after WAIT_RESP
//    entry, busy=0; next snd_cmd clears timeout.
//  6 rst_n asserted during 2nd byte's WAIT_TX -> outputs 0; new snd_cmd restarts at byte 0.

Source files
------------

// File: rtl/uart_cmd_sender.sv
// Host-side UART command initiator: sends NUM_BYTES MSB-first, then captures a one-byte reply.
// Optional response timeout is compiled in with `define RESP_TIMEOUT_EN.
module uart_cmd_sender #(
   parameter int NUM_BYTES    = 3,
   parameter int RESP_TIMEOUT = 1_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   snd_cmd,
   input  logic [8*NUM_BYTES-1:0] cmd,
   output logic                   trmt,
   output logic [7:0]             tx_data,
   input  logic                   tx_done,
   input  logic                   rdy,
   input  logic [7:0]             rx_data,
   output logic                   clr_rdy,
   output logic                   busy,
   output logic                   cmd_sent,
   output logic                   resp_rdy,
   output logic [7:0]             resp,
   output logic                   timeout
);

   localparam int CMD_W = 8 * NUM_BYTES;
   localparam int CNT_W = $clog2(NUM_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_TX, WAIT_RESP} state_t;

   state_t           state, state_n;
   logic [CMD_W-1:0] shift_reg;
   logic [CNT_W-1:0] byte_cnt;
   logic             tx_done_q;
   logic             tx_edge;
   logic             last_byte;
   logic             accept;
   logic             shift_en;
   logic             take_resp;
   logic             time_out;

`ifdef RESP_TIMEOUT_EN
   localparam int TO_W = $clog2(RESP_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT - 1);
   logic [TO_W-1:0] to_cnt;
`endif

   // Only a low-to-high transition counts, so a tx_done left high by the previous byte is ignored.
   assign tx_edge   = tx_done & ~tx_done_q;
   assign last_byte = (byte_cnt == LAST_BYTE);
   assign trmt      = (state == LOAD);
   assign tx_data   = shift_reg[CMD_W-1 -: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      shift_en  = 1'b0;
      take_resp = 1'b0;
      time_out  = 1'b0;
      case (state)
         IDLE: begin
            if (snd_cmd) begin
               accept  = 1'b1;
               state_n = LOAD;
            end
         end
         LOAD: state_n = WAIT_TX;
         WAIT_TX: begin
            if (tx_edge) begin
               shift_en = 1'b1;
               state_n  = last_byte ? WAIT_RESP : LOAD;
            end
         end
         WAIT_RESP: begin
            if (rdy) begin
               take_resp = 1'b1;
               state_n   = IDLE;
            end
`ifdef RESP_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
               time_out = 1'b1;
               state_n  = IDLE;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         byte_cnt  <= '0;
         tx_done_q <= 1'b0;
         clr_rdy   <= 1'b0;
         busy      <= 1'b0;
         cmd_sent  <= 1'b0;
         resp_rdy  <= 1'b0;
         resp      <= 8'h00;
      end else begin
         tx_done_q <= tx_done;
         clr_rdy   <= 1'b0;
         cmd_sent  <= 1'b0;
         // The accept-time clr_rdy flushes any stale byte so only the true reply is captured.
         if (accept) begin
            shift_reg <= cmd;
            byte_cnt  <= '0;
            resp_rdy  <= 1'b0;
            clr_rdy   <= 1'b1;
            busy      <= 1'b1;
         end
         if (shift_en) begin
            shift_reg <= shift_reg << 8;
            byte_cnt  <= byte_cnt + 1'b1;
            if (last_byte) cmd_sent <= 1'b1;
         end
         if (take_resp) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
            clr_rdy  <= 1'b1;
            busy     <= 1'b0;
         end
         if (time_out) busy <= 1'b0;
      end
   end

`ifdef RESP_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (accept) timeout <= 1'b0;
         if (shift_en && last_byte) to_cnt <= '0;
         else if (state == WAIT_RESP) to_cnt <= to_cnt + 1'b1;
         if (time_out) timeout <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Scoreboard bench for uart_cmd_sender: stimulus pushes expected tx bytes and replies,
// a monitor pops and compares them as the DUT produces trmt and resp_rdy.
module tb_uart_cmd_sender;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        snd_cmd;
   logic [23:0] cmd;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        rdy;
   logic [7:0]  rx_data;
   logic        clr_rdy;
   logic        busy;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_tx[$];
   logic [7:0] exp_resp[$];
   logic       resp_rdy_q = 1'b0;

   uart_cmd_sender #(.NUM_BYTES(3), .RESP_TIMEOUT(50)) dut (
      .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd),
      .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
      .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
      .busy(busy), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy),
      .resp(resp), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Transmitter model: trmt clears tx_done, which rises again a few cycles later.
   initial begin
      tx_done = 1'b1;
      forever begin
         @(negedge clk);
         if (trmt) begin
            tx_done = 1'b0;
            repeat (4) @(negedge clk);
            tx_done = 1'b1;
         end
      end
   end

   // Monitor: compares every trmt byte, cmd_sent and new response against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (trmt) begin
            if (exp_tx.size() == 0) check_output("trmt_unexpected", {31'd0, trmt}, 32'd0);
            else check_output("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
         end
         if (cmd_sent) check_output("cmd_sent_bytes_left", exp_tx.size(), 32'd0);
         if (resp_rdy && !resp_rdy_q) begin
            if (exp_resp.size() == 0) check_output("resp_unexpected", {31'd0, resp_rdy}, 32'd0);
            else check_output("resp", {24'd0, resp}, {24'd0, exp_resp.pop_front()});
         end
         resp_rdy_q = resp_rdy;
      end
   end

   task automatic apply_stimulus(input logic [23:0] c);
      @(negedge clk);
      cmd     = c;
      snd_cmd = 1'b1;
      exp_tx.push_back(c[23:16]);
      exp_tx.push_back(c[15:8]);
      exp_tx.push_back(c[7:0]);
      @(negedge clk);
      snd_cmd = 1'b0;
      check_output("accept_clr_rdy", {31'd0, clr_rdy}, 32'd1);
      check_output("accept_busy", {31'd0, busy}, 32'd1);
      check_output("accept_timeout_clear", {31'd0, timeout}, 32'd0);
      rdy = 1'b0;
   endtask

   task automatic wait_cmd_sent();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (cmd_sent) break;
      end
      check_output("wait_cmd_sent", {31'd0, cmd_sent}, 32'd1);
   endtask

   task automatic wait_clr_rdy();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (clr_rdy) break;
      end
      check_output("wait_clr_rdy", {31'd0, clr_rdy}, 32'd1);
      rdy = 1'b0;
   endtask

   task automatic respond(input logic [7:0] b);
      exp_resp.push_back(b);
      rx_data = b;
      rdy     = 1'b1;
      wait_clr_rdy();
      check_output("resp_busy_low", {31'd0, busy}, 32'd0);
      check_output("resp_rdy_high", {31'd0, resp_rdy}, 32'd1);
   endtask

   task automatic wait_tx_left(input int n);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (exp_tx.size() == n) break;
      end
      check_output("wait_tx_left", exp_tx.size(), n);
   endtask

   initial begin
      rst_n = 1'b0; snd_cmd = 1'b0; cmd = '0; rdy = 1'b0; rx_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_output("rst_trmt", {31'd0, trmt}, 32'd0);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
      check_output("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
      check_output("rst_resp", {24'd0, resp}, 32'd0);
      check_output("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check_output("rst_timeout", {31'd0, timeout}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_output("idle_busy", {31'd0, busy}, 32'd0);

      // Basic command and reply
      apply_stimulus(24'hA5_3C_0F);
      wait_cmd_sent();
      respond(8'hA5);

      // snd_cmd while busy is ignored
      apply_stimulus(24'hA5_3C_0F);
      repeat (3) @(negedge clk);
      cmd = 24'hFF_FFFF; snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
      wait_cmd_sent();
      respond(8'h3C);

      // Stale byte flushed at accept, reply arriving mid-transmit taken on entry
      rx_data = 8'h11; rdy = 1'b1;
      apply_stimulus(24'h01_02_03);
      wait_tx_left(1);
      exp_resp.push_back(8'h5A);
      rx_data = 8'h5A; rdy = 1'b1;
      wait_cmd_sent();
      wait_clr_rdy();
      check_output("pending_resp_rdy", {31'd0, resp_rdy}, 32'd1);

`ifdef RESP_TIMEOUT_EN
      // Response timeout after 50 cycles in WAIT_RESP
      apply_stimulus(24'h77_88_99);
      wait_cmd_sent();
      repeat (49) @(negedge clk);
      check_output("timeout_early", {31'd0, timeout}, 32'd0);
      @(negedge clk);
      check_output("timeout_set", {31'd0, timeout}, 32'd1);
      check_output("timeout_busy", {31'd0, busy}, 32'd0);
      check_output("timeout_resp_kept", {24'd0, resp}, 32'h5A);
      apply_stimulus(24'h10_20_30);
      wait_cmd_sent();
      respond(8'h42);
`endif

      // Reset during the second byte, then restart from byte 0
      apply_stimulus(24'h12_34_56);
      wait_tx_left(1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("midrst_trmt", {31'd0, trmt}, 32'd0);
      check_output("midrst_busy", {31'd0, busy}, 32'd0);
      check_output("midrst_tx_data", {24'd0, tx_data}, 32'd0);
      check_output("midrst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
      exp_tx.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      apply_stimulus(24'hC0_FF_EE);
      wait_cmd_sent();
      respond(8'h77);

      repeat (5) @(negedge clk);
      check_output("tx_queue_empty", exp_tx.size(), 32'd0);
      check_output("resp_queue_empty", exp_resp.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
